segment_runner: RTL
===================

# segment_runner

Motion segment executor that sits directly downstream of the record FIFO. It pops one 128-bit record at a time and runs it as a 4-axis DDA (digital differential analyzer), producing step and direction outputs for the stepper drivers. It stays busy until the segment's loop count is exhausted, then fetches the next record.

## Interface
- `StepPulseCycles`, default 4: width of each step pulse in clocks; must be ≥1.
- `DirSetupCycles`, default 8: clocks between a direction update and the first possible step edge; must be ≥1.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `record_in` in 128: FIFO read-port record. The first-written byte is at `[7:0]`.
- `fifo_empty` in 1: FIFO holds no complete record.
- `fifo_read_en` out 1: pop request. It is registered and high for exactly one cycle per fetch.
- `step` out 4: per-axis step pulses. Active high, registered.
- `dir` out 4: per-axis direction. Registered; 1 means positive.
- `busy` out 1: high in any state other than IDLE.
- `segments_done` out 16: count of completed segments; wraps modulo 2^16.

## Operation
- Record layout:
  - `[31:0]` `loops`, unsigned.
  - `[47:32]` `period`, clocks per loop.
  - `[51:48]` `dir_bits`.
  - `[63:52]` reserved; ignored.
  - `[64+16i+15 : 64+16i]` `inc[i]` for axis i = 0..3.
- `period_eff` = max(`period`, `StepPulseCycles`+1).
- FSM states are IDLE, FETCH, SETUP and RUN.
- IDLE:
  - If `fifo_empty` is 0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH (one cycle):
  - `fifo_read_en` is 1 for this cycle.
  - At the exiting edge, latch `record_in` and load `dir` ← `dir_bits`.
  - Clear all four 16-bit accumulators to 0.
  - If `loops` == 0: increment `segments_done` and go to IDLE.
  - Otherwise go to SETUP.
- SETUP:
  - Wait `DirSetupCycles` cycles, then go to RUN.
  - Skip SETUP entirely when the new `dir_bits` equals the current `dir`; go straight from FETCH to RUN.
- RUN:
  - The period counter counts `period_eff` cycles per loop.
  - On the first cycle of each loop (the tick), for each axis: {carry, acc[i]} ← acc[i] + inc[i].
  - If carry = 1, `step[i]` rises at that edge and stays high for `StepPulseCycles` cycles.
  - Each tick decrements the remaining-loops count.
  - After the final loop's `period_eff` cycles complete, increment `segments_done` and go to IDLE.
- A pulse never spans a loop boundary, because `period_eff` > `StepPulseCycles`.
- Reset values: `fifo_read_en`=0, `step`=0, `dir`=0, `busy`=0, `segments_done`=0, state=IDLE, accumulators=0. The latched record is don't-care after reset.
- Reset mid-segment: all outputs go to their reset values immediately (asynchronously). The segment is abandoned, and the records left in the FIFO are not discarded.

## Timing
- Fetch latency: `fifo_empty` falls at cycle N → `fifo_read_en` is high in cycle N+1 → record is latched at the end of N+1.
- First tick:
  - When SETUP is skipped, the first RUN cycle is N+2.
  - Otherwise it is N+2+`DirSetupCycles`.
- Segment duration in RUN is exactly `loops` × `period_eff` cycles.
- Back-to-back segments leave one IDLE cycle and one FETCH cycle between the last RUN cycle and the next RUN or SETUP cycle.
- `dir` never changes while any `step` bit is high, or within `DirSetupCycles` cycles before a step rise.
- An axis with `inc`=0 never steps. An axis with `inc`=0xFFFF steps on every tick except the first.

## Configuration
- `SEGMENT_RUNNER_POSITION_EN` defined:
  - Adds output `position` (out, 4×32, signed, packed with axis i at `[32i+31:32i]`).
  - Each step rise adds +1 to that axis if `dir[i]`=1, otherwise −1.
  - 32-bit two's-complement wrap.
  - Reset value 0.
- `SEGMENT_RUNNER_POSITION_EN` undefined: the port and the counters do not exist; all other behaviour is identical.

## Test plan
- Reset release with `fifo_empty`=1 for 20 cycles → `busy`=0, `fifo_read_en`=0, `step`=0, `segments_done`=0.
- Record `loops`=4, `period`=10, `dir_bits`=0, `inc`={0x8000,0xFFFF,0,0x4000} → steps per axis {2,3,0,1}.
  - RUN lasts 40 cycles.
  - Each pulse is 4 cycles wide.
  - `segments_done`=1.
- Record `period`=2, `loops`=3 → `period_eff`=5, RUN lasts 15 cycles, and pulses are spaced ≥5 cycles.
- Two queued records with `dir_bits` 0x0 then 0xF:
  - Exactly one FETCH per record.
  - `dir` changes only after `segments_done`=1.
  - First step of the second record appears ≥8 cycles after `dir` changes.
- Record `loops`=0 → one FETCH, no step pulses, `segments_done` increments, back in IDLE after 2 cycles.
- `reset` asserted mid-RUN while `step` is high → `step`=0 in the same cycle. After release, the runner fetches the next queued record.
- With `SEGMENT_RUNNER_POSITION_EN` defined, run the second scenario with `dir_bits`=0x2 → `position` = {−2,+3,0,−1} for axes {0,1,2,3}.

Source files
------------

// File: rtl/segment_runner.sv
// Four-axis DDA segment executor: pops 128-bit records from the upstream FIFO and emits step/dir.
// Optional SEGMENT_RUNNER_POSITION_EN adds signed per-axis position counters on output `position`.
module segment_runner #(
    parameter int unsigned StepPulseCycles = 4,
    parameter int unsigned DirSetupCycles  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] record_in,
    input  logic         fifo_empty,
    output logic         fifo_read_en,
    output logic [3:0]   step,
    output logic [3:0]   dir,
    output logic         busy,
    output logic [15:0]  segments_done
`ifdef SEGMENT_RUNNER_POSITION_EN
    ,
    output logic [127:0] position
`endif
);

    localparam int unsigned MinPeriod = StepPulseCycles + 1;
    localparam int unsigned PulseW    = (StepPulseCycles > 1) ? $clog2(StepPulseCycles) : 1;
    localparam int unsigned SetupW    = (DirSetupCycles > 1) ? $clog2(DirSetupCycles) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SETUP = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   rd_en_q, rd_en_d;
    logic [3:0]             step_q, step_d;
    logic [3:0]             dir_q, dir_d;
    logic                   busy_q, busy_d;
    logic [15:0]            seg_q, seg_d;
    logic [31:0]            loops_q, loops_d;
    logic [15:0]            period_q, period_d;
    logic [15:0]            pcnt_q, pcnt_d;
    logic [SetupW-1:0]      setup_q, setup_d;
    logic [3:0][15:0]       inc_q, inc_d;
    logic [3:0][15:0]       acc_q, acc_d;
    logic [3:0][PulseW-1:0] pulse_q, pulse_d;
    logic [3:0][16:0]       sum_c;
    logic [15:0]            rec_period_c;
    logic [15:0]            period_eff_c;
    logic                   tick_c;
    logic                   unused_rsvd_c;
`ifdef SEGMENT_RUNNER_POSITION_EN
    logic [127:0]           pos_q, pos_d;
`endif

    assign unused_rsvd_c = ^record_in[63:52];
    assign rec_period_c  = record_in[47:32];
    assign period_eff_c  = (rec_period_c < 16'(MinPeriod)) ? 16'(MinPeriod) : rec_period_c;
    assign tick_c        = (state_q == RUN) && (pcnt_q == '0);

    // Per-axis accumulator sums; bit 16 is the step carry.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum_c[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        dir_d    = dir_q;
        seg_d    = seg_q;
        loops_d  = loops_q;
        period_d = period_q;
        pcnt_d   = pcnt_q;
        setup_d  = setup_q;
        inc_d    = inc_q;
        acc_d    = acc_q;
        pulse_d  = pulse_q;
`ifdef SEGMENT_RUNNER_POSITION_EN
        pos_d    = pos_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                loops_d  = record_in[31:0];
                period_d = period_eff_c;
                inc_d    = record_in[127:64];
                acc_d    = '0;
                pcnt_d   = '0;
                setup_d  = SetupW'(DirSetupCycles - 1);
                dir_d    = record_in[51:48];
                if (record_in[31:0] == '0) begin
                    seg_d   = seg_q + 16'd1;
                    state_d = IDLE;
                end else if (record_in[51:48] == dir_q) begin
                    state_d = RUN;
                end else begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (setup_q == '0) begin
                    state_d = RUN;
                end else begin
                    setup_d = setup_q - SetupW'(1);
                end
            end
            RUN: begin
                if (tick_c) begin
                    loops_d = loops_q - 32'd1;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = sum_c[i][15:0];
                    end
                end
                // period_eff >= 2, so the tick has already decremented loops on the last cycle.
                if (pcnt_q == period_q - 16'd1) begin
                    pcnt_d = '0;
                    if (loops_q == '0) begin
                        seg_d   = seg_q + 16'd1;
                        state_d = IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Step pulse stretchers; a carry on the tick starts a fixed-width pulse.
        for (int i = 0; i < 4; i++) begin
            if (tick_c && sum_c[i][16]) begin
                step_d[i]  = 1'b1;
                pulse_d[i] = PulseW'(StepPulseCycles - 1);
`ifdef SEGMENT_RUNNER_POSITION_EN
                pos_d[32*i +: 32] = pos_q[32*i +: 32] + (dir_q[i] ? 32'd1 : 32'hFFFF_FFFF);
`endif
            end else if (step_q[i]) begin
                if (pulse_q[i] == '0) begin
                    step_d[i] = 1'b0;
                end else begin
                    pulse_d[i] = pulse_q[i] - PulseW'(1);
                end
            end
        end

        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_en_q  <= 1'b0;
            step_q   <= '0;
            dir_q    <= '0;
            busy_q   <= 1'b0;
            seg_q    <= '0;
            loops_q  <= '0;
            period_q <= '0;
            pcnt_q   <= '0;
            setup_q  <= '0;
            inc_q    <= '0;
            acc_q    <= '0;
            pulse_q  <= '0;
`ifdef SEGMENT_RUNNER_POSITION_EN
            pos_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_en_q  <= rd_en_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            seg_q    <= seg_d;
            loops_q  <= loops_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            setup_q  <= setup_d;
            inc_q    <= inc_d;
            acc_q    <= acc_d;
            pulse_q  <= pulse_d;
`ifdef SEGMENT_RUNNER_POSITION_EN
            pos_q    <= pos_d;
`endif
        end
    end

    assign fifo_read_en  = rd_en_q;
    assign step          = step_q;
    assign dir           = dir_q;
    assign busy          = busy_q;
    assign segments_done = seg_q;
`ifdef SEGMENT_RUNNER_POSITION_EN
    assign position      = pos_q;
`endif

endmodule
